iddmm_prod_acc: RTL

IDDMM_PROD_ACC -- requirements
Module: iddmm_prod_acc

---
 rtl/iddmm_prod_acc.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/iddmm_prod_acc.sv
`default_nettype none
// ============================================================================
// Module   : iddmm_prod_acc
// Brief    : Aligns multiplier products with their issue tags, accumulates them,
//            emits 128-bit column words and a final two-word flush with carry.
// Revision : 1.0 - initial release
// ============================================================================
module iddmm_prod_acc #(
  parameter int LAT   = 8,
  parameter int GUARD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             flush,
  input  logic [255:0]     prod,
  output logic             out_valid,
  output logic [127:0]     out_word,
  output logic             done,
  output logic [GUARD-1:0] carry_out,
  output logic             busy,
  output logic             err
);

  localparam int c_ACC_W = 256 + GUARD;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_FLUSH0 = 3'd3,
    S_FLUSH1 = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LAT-1:0]       r_tag_v;
  logic [LAT-1:0]       r_tag_l;
  logic [c_ACC_W-1:0]   r_acc;
  logic [c_ACC_W-1:0]   w_sum;
  logic                 w_run;
  logic                 w_proc;
  logic                 w_load_v;
  logic                 w_load_l;
  logic                 w_al_v;
  logic                 w_al_l;
  logic                 w_in_flight;

  assign w_run       = (r_state == S_RUN);
  assign w_proc      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_load_v    = in_valid & w_run;
  assign w_load_l    = in_last & w_load_v;
  assign w_al_v      = r_tag_v[LAT-1];
  assign w_al_l      = r_tag_l[LAT-1];
  assign w_in_flight = |r_tag_v;
  assign w_sum       = r_acc + {{GUARD{1'b0}}, prod};
  assign busy        = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = S_IDLE;
      S_RUN:    if (flush) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (!w_in_flight) w_state_nxt = S_FLUSH0;
      S_FLUSH0: w_state_nxt = S_FLUSH1;
      S_FLUSH1: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (start) w_state_nxt = S_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Tag pipeline mirrors the multiplier latency so the tag exits alongside prod.
  generate
    if (LAT > 1) begin : g_tag_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tag_v <= '0;
          r_tag_l <= '0;
        end else if (start) begin
          r_tag_v <= '0;
          r_tag_l <= '0;
        end else begin
          r_tag_v <= {r_tag_v[LAT-2:0], w_load_v};
          r_tag_l <= {r_tag_l[LAT-2:0], w_load_l};
        end
      end
    end else begin : g_tag_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tag_v <= '0;
          r_tag_l <= '0;
        end else if (start) begin
          r_tag_v <= '0;
          r_tag_l <= '0;
        end else begin
          r_tag_v <= w_load_v;
          r_tag_l <= w_load_l;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      done      <= 1'b0;
      carry_out <= '0;
      err       <= 1'b0;
    end else if (start) begin
      r_acc     <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      carry_out <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (w_proc && w_al_v) begin
        if (w_al_l) begin
          out_word  <= w_sum[127:0];
          out_valid <= 1'b1;
          r_acc     <= w_sum >> 128;
        end else begin
          r_acc <= w_sum;
        end
      end
      case (r_state)
        S_FLUSH0: begin
          out_word  <= r_acc[127:0];
          out_valid <= 1'b1;
        end
        S_FLUSH1: begin
          out_word  <= r_acc[255:128];
          out_valid <= 1'b1;
        end
        S_DONE: begin
          done      <= 1'b1;
          carry_out <= r_acc[c_ACC_W-1:256];
        end
        default: ;
      endcase
      if ((in_valid || flush) && !w_run) err <= 1'b1;
    end
  end

endmodule
`default_nettype wire
